// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the IF_RX command receiver.
// Holds the bit-FSM state enum, default parameters and width helpers.
`timescale 1ns/1ps
package uart_rx_pkg;

   localparam int DEF_CLKS_PER_BIT = 434;
   localparam int DEF_TIMEOUT_BITS = 20;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   // Sampling point of the start bit, in clocks.
   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

   // Idle clocks after which a partial word is dropped.
   function automatic int timeout_clks(input int cpb, input int bits);
      return cpb * bits;
   endfunction

   // Bits needed to count 0 .. n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_cmd_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, bit FSM and byte outputs.
// Ports: clk, rst_n, uart_rxd in; rx_data, rx_valid, frame_err, busy out.
`timescale 1ns/1ps
module uart_rx_byte
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(CLKS_PER_BIT) - 1);

   logic rxd_m;
   logic rxd_s;

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    data_d;
   logic          valid_d;
   logic          ferr_d;

   // Idle line is high, so the synchroniser resets to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= uart_rxd;
         rxd_s <= rxd_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         rx_data   <= data_d;
         rx_valid  <= valid_d;
         frame_err <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = rx_data;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxd_s) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               // A start bit gone high by mid-bit is a glitch.
               state_d = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               sh_d  = {rxd_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rxd_s) begin
                  data_d  = sh_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold here until the line recovers: one error per break.
            cnt_d = '0;
            if (rxd_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

endmodule

// File: rtl/uart_rx_cmd.sv
// IF_RX command receiver: bytes assembled MSB first into 32-bit words.
// Ports: clk, rst_n, uart_rxd in; byte outputs, word_data/valid, busy.
`timescale 1ns/1ps
module uart_rx_cmd
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        frame_err,
   output logic [31:0] word_data,
   output logic        word_valid,
   output logic        busy
);

   localparam int TO_CLKS = timeout_clks(CLKS_PER_BIT, TIMEOUT_BITS);
   localparam int TW = $clog2(TO_CLKS + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CLKS);

   logic [23:0]   sr;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] to_cnt;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rxd (uart_rxd),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   // rx_valid outranks both frame_err and the timeout limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr         <= '0;
         byte_cnt   <= '0;
         to_cnt     <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (rx_valid) begin
            sr       <= {sr[15:0], rx_data};
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
               word_data  <= {sr, rx_data};
               word_valid <= 1'b1;
            end
         end else if (frame_err) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
         end else if (byte_cnt == 2'd0) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd at 16 clocks per bit.
// Vector table plus hand sequences; byte/word scoreboard queues.
`timescale 1ns/1ps
module tb_uart_rx_cmd;

   localparam int CPB = 16;
   localparam int TOB = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uart_rxd;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic [31:0] word_data;
   logic        word_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int rxv_cnt = 0;
   int fe_cnt = 0;

   logic [7:0]  byte_q[$];
   logic [31:0] word_q[$];
   int          mbcnt = 0;
   logic [31:0] msr = '0;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       stop;
      int         hold_low;
      int         gap;
      int         exp_rv;
      int         exp_fe;
   } vec_t;

   vec_t tbl[18];

   always #5 clk = ~clk;

   uart_rx_cmd #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_BITS(TOB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rxd  (uart_rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .word_data (word_data),
      .word_valid(word_valid),
      .busy      (busy)
   );

   always @(negedge clk) begin : mon
      logic [7:0]  eb;
      logic [31:0] ew;
      if (rx_valid) begin
         rxv_cnt++;
         checks++;
         if (byte_q.size() == 0) begin
            errors++;
            $display("FAIL rx_valid_extra: got rx_data=%02h, required no pulse",
                     rx_data);
         end else begin
            eb = byte_q.pop_front();
            if (rx_data !== eb) begin
               errors++;
               $display("FAIL rx_data: got %02h, required %02h", rx_data, eb);
            end
         end
      end
      if (word_valid) begin
         checks++;
         if (word_q.size() == 0) begin
            errors++;
            $display("FAIL word_valid_extra: got %08h, required no pulse",
                     word_data);
         end else begin
            ew = word_q.pop_front();
            if (word_data !== ew) begin
               errors++;
               $display("FAIL word_data: got %08h, required %08h",
                        word_data, ew);
            end
         end
      end
      if (frame_err) fe_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      uart_rxd = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      bit_time(stop);
      uart_rxd = 1'b1;
   endtask

   task automatic expect_byte(input logic [7:0] d);
      byte_q.push_back(d);
      msr = {msr[23:0], d};
      mbcnt++;
      if (mbcnt == 4) begin
         word_q.push_back(msr);
         mbcnt = 0;
      end
   endtask

   task automatic run_vec(input int idx);
      int r0;
      int f0;
      vec_t v;
      v  = tbl[idx];
      r0 = rxv_cnt;
      f0 = fe_cnt;
      if (v.kind == 0) begin
         if (v.exp_rv != 0) expect_byte(v.data);
         send_frame(v.data, v.stop);
         if (v.hold_low > 0) begin
            uart_rxd = 1'b0;
            repeat (v.hold_low * CPB) @(posedge clk);
            #1;
         end
         uart_rxd = 1'b1;
      end else begin
         uart_rxd = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         uart_rxd = 1'b1;
      end
      if (v.exp_fe != 0) mbcnt = 0;
      repeat (v.gap * CPB + 1) @(posedge clk);
      #1;
      if (v.gap > 10) mbcnt = 0;
      check($sformatf("v%0d_rx_valid_count", idx), rxv_cnt - r0, v.exp_rv);
      check($sformatf("v%0d_frame_err_count", idx), fe_cnt - f0, v.exp_fe);
      check($sformatf("v%0d_busy_idle", idx), busy, 0);
   endtask

   initial begin
      int n;
      int r0;
      int f0;

      tbl[0]  = '{0, 8'hA5, 1'b1, 0, 2, 1, 0};
      tbl[1]  = '{1, 8'h00, 1'b1, 0, 2, 0, 0};
      tbl[2]  = '{0, 8'h5A, 1'b1, 0, 2, 1, 0};
      tbl[3]  = '{0, 8'h3C, 1'b0, 3, 2, 0, 1};
      tbl[4]  = '{0, 8'h3C, 1'b1, 0, 2, 1, 0};
      tbl[5]  = '{0, 8'h01, 1'b1, 0, 0, 1, 0};
      tbl[6]  = '{0, 8'h02, 1'b1, 0, 0, 1, 0};
      tbl[7]  = '{0, 8'h03, 1'b1, 0, 2, 1, 0};
      tbl[8]  = '{0, 8'h12, 1'b1, 0, 0, 1, 0};
      tbl[9]  = '{0, 8'h34, 1'b1, 0, 0, 1, 0};
      tbl[10] = '{0, 8'h56, 1'b1, 0, 0, 1, 0};
      tbl[11] = '{0, 8'h78, 1'b1, 0, 2, 1, 0};
      tbl[12] = '{0, 8'h11, 1'b1, 0, 0, 1, 0};
      tbl[13] = '{0, 8'h22, 1'b1, 0, 25, 1, 0};
      tbl[14] = '{0, 8'hDE, 1'b1, 0, 0, 1, 0};
      tbl[15] = '{0, 8'hAD, 1'b1, 0, 0, 1, 0};
      tbl[16] = '{0, 8'hBE, 1'b1, 0, 0, 1, 0};
      tbl[17] = '{0, 8'hEF, 1'b1, 0, 2, 1, 0};

      rst_n    = 1'b0;
      uart_rxd = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_word_data", word_data, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (CPB) @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) run_vec(i);

      // Latency from start edge to rx_valid, and busy around the frame.
      expect_byte(8'h96);
      n = 0;
      fork
         send_frame(8'h96, 1'b1);
         begin
            while (!rx_valid && n < 400) begin
               @(posedge clk);
               #1;
               n++;
               if (n == 80) check("busy_mid_frame", busy, 1);
            end
            check("busy_after_stop", busy, 0);
         end
      join
      checks++;
      if (n < 154 || n > 156) begin
         errors++;
         $display("FAIL rx_latency: got %0d cycles, required 154..156", n);
      end
      repeat (2 * CPB) @(posedge clk);
      #1;

      // Reset during data bit 4 of a frame.
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b1);
      uart_rxd = 1'b0;
      repeat (CPB / 2) @(posedge clk);
      #1;
      check("mid_busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_rx_data", rx_data, 0);
      check("midrst_word_data", word_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_word_valid", word_valid, 0);
      mbcnt = 0;
      repeat (4) @(posedge clk);
      #1;
      uart_rxd = 1'b1;
      rst_n    = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      r0 = rxv_cnt;
      f0 = fe_cnt;
      expect_byte(8'hC3);
      send_frame(8'hC3, 1'b1);
      repeat (2 * CPB) @(posedge clk);
      #1;
      check("post_rst_rx_count", rxv_cnt - r0, 1);
      check("post_rst_frame_err", fe_cnt - f0, 0);
      check("post_rst_rx_data", rx_data, 8'hC3);

      check("bytes_outstanding", byte_q.size(), 0);
      check("words_outstanding", word_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
UART (8N1) receiver for the USB-UART IF_RX line. It is the counterpart of the existing UART transmitter on IF_TX.
Runs on CLKB. Deserialises bytes and assembles 4 bytes, MSB first, into a 32-bit command word. The word feeds the control path (DAC/SPI command generator, ext reset, trigger control) without going through the soft-core.

Parameters:
CLKS_PER_BIT, 434, CLKB cycles per UART bit (CLKB/baud); minimum 8.
TIMEOUT_BITS, 20, idle bit-times after which a partially assembled word is discarded.

Ports:
clk  input  1  system clock (CLKB); all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
uart_rxd  input  1  raw serial input from IF_RX; idle high; asynchronous to clk.
rx_data  output  8  last correctly received byte; held until the next good byte.
rx_valid  output  1  one-cycle pulse; rx_data was updated this cycle.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
word_data  output  32  last assembled command word; first byte in [31:24].
word_valid  output  1  one-cycle pulse; word_data was updated this cycle.
busy  output  1  high whenever the bit FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, word_data=0, word_valid=0, busy=0, byte count=0, FSM=IDLE. Synchroniser flops reset to 1.
- Input synchroniser: 2-FF on uart_rxd, giving rxd_s. Everything below uses rxd_s only.
- Bit FSM states and transitions, using one counter cnt and one bit index:
  - IDLE: when rxd_s==0, go to START with cnt=0.
  - START: when cnt==CLKS_PER_BIT/2-1, sample rxd_s. If 0, go to DATA with cnt=0, bit=0. If 1 (glitch), go to IDLE with no pulse.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rxd_s in LSB-first and set cnt=0. After bit 7, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rxd_s.
    - If 1: load rx_data, pulse rx_valid on the next cycle, go to IDLE.
    - If 0: pulse frame_err, leave rx_data unchanged, go to BREAK.
  - BREAK: wait for rxd_s==1, then go to IDLE. A line held low never produces repeated errors.
- Latency: rx_valid asserts 2 (sync) + 9.5 bit-times + 1 cycle after the start falling edge, within ±1 cycle.
- Word assembler:
  - On rx_valid: shift sr={sr[23:0],rx_data} and increment byte_cnt (2 bits).
  - When byte_cnt==3 on rx_valid: on the next cycle word_data={sr[23:0],rx_data} and word_valid=1; byte_cnt wraps to 0.
  - frame_err: byte_cnt=0 (partial word discarded).
  - Timeout: idle counter clears on each rx_valid and counts only while byte_cnt!=0. At TIMEOUT_BITS*CLKS_PER_BIT it sets byte_cnt=0, with no pulse.
  - Counter widths: cnt is clog2(CLKS_PER_BIT) bits; the timeout counter is sized for its full count, with no wrap before the limit.
- Simultaneous events:
  - The timeout limit and rx_valid in the same cycle: rx_valid wins; the byte is counted and the timer is cleared.
  - rx_valid and word_valid can coincide only when the 4th byte's word_valid lands on the cycle after its rx_valid; never two word_valid pulses for one word.
- Back-to-back frames: IDLE accepts a new start edge on the cycle after leaving STOP. No inter-frame gap is required beyond the stop bit.
- Reset mid-frame: everything returns to its reset values immediately. The next complete frame after release is received correctly.

Decomposition:
- Package uart_rx_pkg holds:
  - FSM state enum {IDLE, START, DATA, STOP, BREAK};
  - constants HALF_BIT=CLKS_PER_BIT/2 and TIMEOUT_CLKS=TIMEOUT_BITS*CLKS_PER_BIT;
  - a function for counter width.
- Sub-module uart_rx_byte contains the synchroniser, bit FSM, rx_data, rx_valid and frame_err.
- uart_rx_cmd instantiates uart_rx_byte and adds the word assembler and timeout.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_BITS=20):
1. Send byte 0xA5 at the nominal rate -> exactly one rx_valid, rx_data=0xA5, frame_err never high, busy falls after the stop sample.
2. Drive rxd low for 5 clocks then high -> no rx_valid, no frame_err, FSM back in IDLE; a following 0x5A is received correctly.
3. Frame 0x3C with the stop bit low, then hold the line low for 3 bit-times, then send 0x3C normally -> one frame_err pulse, no rx_valid for the bad frame, then rx_valid with 0x3C; byte_cnt restarted.
4. Bytes 0x12,0x34,0x56,0x78 back-to-back -> four rx_valid pulses, one word_valid, word_data=0x12345678.
5. Bytes 0x11,0x22, then 25 bit-times idle, then 0xDE,0xAD,0xBE,0xEF -> a single word_valid with 0xDEADBEEF; the partial word is never emitted.
6. Assert rst_n low during DATA bit 4 of a frame, release, send 0xC3 -> outputs zero during reset, then rx_valid with 0xC3 and no frame_err.
